// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic datapath: FSM encodings and default
// operand/digit widths used by the serial arithmetic blocks.
package arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DIGIT = 4;

endpackage

// File: rtl/sub_digit.sv
// Combinational DIGIT-bit borrow-ripple slice built from full-subtractor
// cells: {o_bout, o_d} = i_a - i_b - i_bin.
module sub_digit
  import arith_pkg::*;
#(
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  input  logic             i_bin,
  output logic [DIGIT-1:0] o_d,
  output logic             o_bout
);

  logic [DIGIT:0] bw;

  assign bw[0] = i_bin;

  // Full subtractor: borrow out when a < b + bin for this bit.
  for (genvar g = 0; g < DIGIT; g++) begin : g_cell
    assign o_d[g]    = i_a[g] ^ i_b[g] ^ bw[g];
    assign bw[g+1]   = (~i_a[g] & i_b[g]) | (~(i_a[g] ^ i_b[g]) & bw[g]);
  end

  assign o_bout = bw[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: computes i_a - i_b one DIGIT-wide slice per cycle,
// LSB digit first, reporting unsigned borrow and signed overflow.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow,
  output logic             o_ovf,
  output logic             o_busy
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH % DIGIT) != 0 || N < 2) begin : g_bad_params
    $error("serial_subtractor: WIDTH must be a multiple of DIGIT with at least two digits");
  end

  state_t state, state_nxt;

  logic [CNT_W-1:0]       cnt;
  logic                   borrow;
  logic [WIDTH-1:0]       a_reg;
  logic [WIDTH-1:0]       b_reg;
  logic [WIDTH-DIGIT-1:0] diff_reg;
  logic                   a_msb;
  logic                   b_msb;

  logic [DIGIT-1:0]       d;
  logic                   bout;
  logic [WIDTH-1:0]       diff_full;
  logic                   accept;
  logic                   step;
  logic                   last;

  sub_digit #(
    .DIGIT (DIGIT)
  ) u_slice (
    .i_a    (a_reg[DIGIT-1:0]),
    .i_b    (b_reg[DIGIT-1:0]),
    .i_bin  (borrow),
    .o_d    (d),
    .o_bout (bout)
  );

  assign accept    = (state == ST_IDLE) && i_valid;
  assign step      = (state == ST_BUSY);
  assign last      = step && (cnt == CNT_W'(N - 1));
  // Already-computed digits sit below the new one; on the last step this is the full result.
  assign diff_full = {d, diff_reg};

  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    o_valid   = 1'b0;
    o_busy    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        o_busy = 1'b1;
        if (cnt == CNT_W'(N - 1)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        o_valid = 1'b1;
        if (i_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      borrow   <= 1'b0;
      o_diff   <= '0;
      o_borrow <= 1'b0;
      o_ovf    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt    <= '0;
        borrow <= 1'b0;
      end else if (step) begin
        cnt    <= last ? '0 : cnt + CNT_W'(1);
        borrow <= bout;
      end
      if (last) begin
        o_diff   <= diff_full;
        o_borrow <= bout;
        o_ovf    <= (a_msb != b_msb) && (d[DIGIT-1] != a_msb);
      end
    end
  end

  // Operand/partial-result shift registers carry no reset: they are reloaded on every accept.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      a_reg <= i_a;
      b_reg <= i_b;
      a_msb <= i_a[WIDTH-1];
      b_msb <= i_b[WIDTH-1];
    end else if (step) begin
      a_reg    <= a_reg >> DIGIT;
      b_reg    <= b_reg >> DIGIT;
      diff_reg <= diff_full[WIDTH-1:DIGIT];
    end
  end

endmodule
